pw_pool_pingpong_buffer: RTL and testbench
==========================================

Name: pw_pool_pingpong_buffer

Overview:
Parametrised ping-pong buffer between the pointwise-conv array and the pooling unit.
- Write side: accumulates partial sums across input channels, LANES output channels per word, then commits the word to the current write bank.
- Read side: the pool stage reads a completed bank while the other bank fills.
- Successor to the fixed 8-lane two-bank intermediate buffer. Adds configurable width/lanes/depth, explicit full/empty bank handshake, overflow/underflow flags and optional saturation.

Parameters:
DATA_WIDTH, 16, signed two's-complement width of one lane
LANES, 8, lanes (output channels) per buffer word
DEPTH, 32, words per bank (output-channel groups)
ADDR_WIDTH, 5, address width; DEPTH <= 2**ADDR_WIDTH

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  partial-sum word present
in_first  in  1  first input channel of this word: load instead of add
in_last  in  1  last input channel: commit result to bank
in_addr  in  ADDR_WIDTH  output-channel group address in write bank
in_data  in  DATA_WIDTH*LANES  partial sums, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
in_ready  out  1  current write bank not full
row_done  in  1  write bank complete; hand it to read side
rd_avail  out  1  current read bank full and readable
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read word address
rd_data  out  DATA_WIDTH*LANES  read word
rd_valid  out  1  rd_data valid this cycle
rd_release  in  1  pool stage finished with read bank
ovf_err  out  1  sticky: write/row_done while write bank full
udf_err  out  1  sticky: rd_en/rd_release while no bank readable

Behaviour:
- Reset (async, rst_n=0): acc=0, wb=0, rb=0, full[1:0]=0.
  - Outputs: in_ready=1, rd_avail=0, rd_valid=0, rd_data=0, ovf_err=0, udf_err=0.
  - Bank RAM contents are not reset.
- Bank state: full[b] flag per bank; write pointer wb, read pointer rb.
  - in_ready = !full[wb]; rd_avail = full[rb].
- Accepted write (in_valid && in_ready):
  - Per-lane sum = in_first ? in_data lane : acc lane + in_data lane.
  - Result is DATA_WIDTH wide; wrapping unless SATURATE_EN.
  - acc <= sum at the same edge.
  - If in_last: bank[wb][in_addr] <= sum at the same edge.
  - Readable from the read side the cycle after row_done hands over the bank.
- in_valid && !in_ready: word dropped, acc unchanged, ovf_err <= 1.
- in_addr >= DATA DEPTH: write suppressed, no flag.
- row_done with !full[wb]: full[wb] <= 1, wb <= ~wb. Accepted in_last in the same cycle writes the old wb first.
- row_done with full[wb]: ignored, ovf_err <= 1.
- rd_en with full[rb]: rd_data <= bank[rb][rd_addr], rd_valid <= 1 next cycle (1-cycle latency).
- rd_en with !full[rb]: rd_valid <= 0, rd_data holds, udf_err <= 1.
- rd_en low: rd_valid <= 0.
- rd_release with full[rb]: full[rb] <= 0, rb <= ~rb. rd_en in the same cycle reads the old rb.
- rd_release with !full[rb]: ignored, udf_err <= 1.
- Simultaneous row_done and rd_release: legal. They act on different banks, except when wb==rb. In that case row_done requires !full, release requires full, so exactly one takes effect.
- Both banks full: in_ready=0 until the next rd_release. in_ready rises the cycle after release.
- Errors clear only on reset.
- Reset mid-fill: partially accumulated acc and half-filled bank are discarded; pointers return to bank 0.

Optional Feature:
SATURATE_EN
- Defined: per-lane signed add clamps to +(2^(DATA_WIDTH-1)-1) or -2^(DATA_WIDTH-1) on overflow.
- Undefined: plain two's-complement wrap.
- Load path (in_first) is identical in both builds.

Test Plan:
- Accumulate, LANES=8, addr 2: three words with all lanes 1, 2, 3 (first on word 1, last on word 3), then row_done -> rd_addr=2 returns all lanes 6; rd_valid high 1 cycle after rd_en.
- Ping-pong: fill bank0 (addr 0..31 = addr value), row_done, fill bank1 with 100+addr while reading bank0 -> reads return addr; after rd_release and second row_done, reads return 100+addr; rd_avail and in_ready never both low except when both banks full.
- Backpressure: two row_done with no release -> in_ready=0; further in_valid -> dropped, ovf_err=1; rd_release -> in_ready=1 next cycle.
- Saturation: acc lane 0x7FF0 + 0x0020 -> 0x7FFF with SATURATE_EN, 0x8010 without; 0x8005 + 0xFFF0 -> 0x8000 with SATURATE_EN.
- Underflow: rd_release and rd_en after reset with no row_done -> udf_err=1, rd_valid=0, rd_data=0.
- Async reset mid-fill: assert rst_n=0 between edges during accumulation -> all outputs at reset values immediately; after release, a fresh fill into bank 0 reads back correctly.

Source files
------------

// File: rtl/pw_pool_pingpong_buffer_if.sv
// Bus between the pointwise-conv array / pooling unit and the ping-pong buffer.
// master drives write/read requests; slave is the buffer itself.
interface pw_pool_pingpong_buffer_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANES      = 8,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                          in_valid;
    logic                          in_first;
    logic                          in_last;
    logic [ADDR_WIDTH-1:0]         in_addr;
    logic [DATA_WIDTH*LANES-1:0]   in_data;
    logic                          in_ready;
    logic                          row_done;
    logic                          rd_avail;
    logic                          rd_en;
    logic [ADDR_WIDTH-1:0]         rd_addr;
    logic [DATA_WIDTH*LANES-1:0]   rd_data;
    logic                          rd_valid;
    logic                          rd_release;
    logic                          ovf_err;
    logic                          udf_err;

    modport master (
        output in_valid, in_first, in_last, in_addr, in_data, row_done,
               rd_en, rd_addr, rd_release,
        input  in_ready, rd_avail, rd_data, rd_valid, ovf_err, udf_err
    );

    modport slave (
        input  in_valid, in_first, in_last, in_addr, in_data, row_done,
               rd_en, rd_addr, rd_release,
        output in_ready, rd_avail, rd_data, rd_valid, ovf_err, udf_err
    );
endinterface

// File: rtl/pw_pool_pingpong_buffer.sv
// Two-bank ping-pong buffer: accumulates LANES-wide partial sums into the write
// bank while the pool stage reads the other. `SATURATE_EN selects clamping adds.
module pw_pool_pingpong_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANES      = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input logic                      clk,
    input logic                      rst_n,
    pw_pool_pingpong_buffer_if.slave bus
);
    localparam int unsigned WORD_W = DATA_WIDTH * LANES;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [1:0]        full_q, full_d;
    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic              in_ready_q, in_ready_d;
    logic              rd_avail_q, rd_avail_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic              ovf_err_q, ovf_err_d;
    logic              udf_err_q, udf_err_d;

    logic [WORD_W-1:0] bank_mem [2][DEPTH];

    logic [WORD_W-1:0] sum_c;
    logic              wr_accept_c;
    logic              mem_we_c;
    logic              in_addr_ok_c;
    logic              rd_addr_ok_c;

    // Signed lane add; clamps instead of wrapping when saturation is built in.
    function automatic logic [DATA_WIDTH-1:0] lane_add(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] ext;
        ext = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
`ifdef SATURATE_EN
        if (ext[DATA_WIDTH] != ext[DATA_WIDTH-1]) begin
            return ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`endif
        return ext[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            sum_c[i*DATA_WIDTH +: DATA_WIDTH] = bus.in_first
                ? bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]
                : lane_add(acc_q[i*DATA_WIDTH +: DATA_WIDTH],
                           bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Bank bookkeeping, accumulator, read port and sticky error flags.
    always_comb begin
        acc_d        = acc_q;
        full_d       = full_q;
        wb_d         = wb_q;
        rb_d         = rb_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        ovf_err_d    = ovf_err_q;
        udf_err_d    = udf_err_q;

        in_addr_ok_c = 32'(bus.in_addr) < DEPTH;
        rd_addr_ok_c = 32'(bus.rd_addr) < DEPTH;
        wr_accept_c  = bus.in_valid && !full_q[wb_q];
        mem_we_c     = wr_accept_c && bus.in_last && in_addr_ok_c;

        if (wr_accept_c) begin
            acc_d = sum_c;
        end else if (bus.in_valid) begin
            ovf_err_d = 1'b1;
        end

        // row_done and rd_release test the current flags, so when wb==rb only one fires.
        if (bus.row_done) begin
            if (!full_q[wb_q]) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end else begin
                ovf_err_d = 1'b1;
            end
        end

        if (bus.rd_release) begin
            if (full_q[rb_q]) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end else begin
                udf_err_d = 1'b1;
            end
        end

        if (bus.rd_en) begin
            if (full_q[rb_q]) begin
                rd_valid_d = 1'b1;
                rd_data_d  = rd_addr_ok_c ? bank_mem[rb_q][IDX_W'(bus.rd_addr)] : '0;
            end else begin
                udf_err_d = 1'b1;
            end
        end

        in_ready_d = !full_d[wb_d];
        rd_avail_d = full_d[rb_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            full_q     <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            in_ready_q <= 1'b1;
            rd_avail_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ovf_err_q  <= 1'b0;
            udf_err_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            full_q     <= full_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            in_ready_q <= in_ready_d;
            rd_avail_q <= rd_avail_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            ovf_err_q  <= ovf_err_d;
            udf_err_q  <= udf_err_d;
        end
    end

    // Bank storage carries no reset; the full flags gate all reads.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            bank_mem[wb_q][IDX_W'(bus.in_addr)] <= sum_c;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.rd_avail = rd_avail_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.ovf_err  = ovf_err_q;
    assign bus.udf_err  = udf_err_q;

endmodule

// File: tb/tb_pw_pool_pingpong_buffer.sv
// Self-checking bench for pw_pool_pingpong_buffer: vector table for lane arithmetic,
// read-data scoreboard, and hand sequences for ping-pong, backpressure and reset.
module tb_pw_pool_pingpong_buffer;
    localparam int unsigned DW = 16;
    localparam int unsigned LN = 8;
    localparam int unsigned DP = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned WW = DW * LN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pw_pool_pingpong_buffer_if #(.DATA_WIDTH(DW), .LANES(LN), .ADDR_WIDTH(AW)) bus ();

    pw_pool_pingpong_buffer #(.DATA_WIDTH(DW), .LANES(LN), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] a0;
        logic [DW-1:0] a1;
        logic [DW-1:0] e_wrap;
        logic [DW-1:0] e_sat;
    } vec_t;

    vec_t              vecs [6];
    logic [WW-1:0]     exp_q [$];
    int                n_chk = 0;
    int                n_fail = 0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    function automatic logic [WW-1:0] rep(input logic [DW-1:0] v);
        logic [WW-1:0] w;
        for (int i = 0; i < int'(LN); i++) w[i*DW +: DW] = v;
        return w;
    endfunction

    function automatic logic [WW-1:0] pp(input int base, input int addr);
        logic [WW-1:0] w;
        for (int i = 0; i < int'(LN); i++) w[i*DW +: DW] = DW'(base + addr + 256 * i);
        return w;
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_unexpected: got rd_valid=1 with data %h, required no read", bus.rd_data);
            end else begin
                chk("rd_data", bus.rd_data, exp_q.pop_front());
            end
        end
    endtask

    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.in_first   = 1'b0;
        bus.in_last    = 1'b0;
        bus.in_addr    = '0;
        bus.in_data    = '0;
        bus.row_done   = 1'b0;
        bus.rd_en      = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_release = 1'b0;
    endtask

    task automatic write(input int addr, input logic [WW-1:0] d, input logic f, input logic l);
        bus.in_valid = 1'b1;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_addr  = AW'(addr);
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic row_done();
        bus.row_done = 1'b1;
        tick();
        bus.row_done = 1'b0;
    endtask

    task automatic release_bank();
        bus.rd_release = 1'b1;
        tick();
        bus.rd_release = 1'b0;
    endtask

    task automatic read(input int addr, input logic [WW-1:0] expv);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(addr);
        exp_q.push_back(expv);
        tick();
        bus.rd_en   = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        vecs[0] = '{a0: 16'h0001, a1: 16'h0005, e_wrap: 16'h0006, e_sat: 16'h0006};
        vecs[1] = '{a0: 16'h7FF0, a1: 16'h0020, e_wrap: 16'h8010, e_sat: 16'h7FFF};
        vecs[2] = '{a0: 16'h8005, a1: 16'hFFF0, e_wrap: 16'h7FF5, e_sat: 16'h8000};
        vecs[3] = '{a0: 16'hFFFF, a1: 16'h0001, e_wrap: 16'h0000, e_sat: 16'h0000};
        vecs[4] = '{a0: 16'h8000, a1: 16'h8000, e_wrap: 16'h0000, e_sat: 16'h8000};
        vecs[5] = '{a0: 16'h4000, a1: 16'h4000, e_wrap: 16'h8000, e_sat: 16'h7FFF};

        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        chkb("rst_in_ready", bus.in_ready, 1'b1);
        chkb("rst_rd_avail", bus.rd_avail, 1'b0);
        chkb("rst_rd_valid", bus.rd_valid, 1'b0);
        chk ("rst_rd_data",  bus.rd_data,  '0);
        chkb("rst_ovf_err",  bus.ovf_err,  1'b0);
        chkb("rst_udf_err",  bus.udf_err,  1'b0);

        // Underflow: release and read with nothing readable.
        bus.rd_en = 1'b1;
        bus.rd_release = 1'b1;
        tick();
        idle();
        chkb("udf_err",      bus.udf_err,  1'b1);
        chkb("udf_rd_valid", bus.rd_valid, 1'b0);
        chk ("udf_rd_data",  bus.rd_data,  '0);
        chkb("udf_ovf_err",  bus.ovf_err,  1'b0);
        chkb("udf_rd_avail", bus.rd_avail, 1'b0);

        // Three-channel accumulation at addr 2.
        apply_reset();
        chkb("rst_clears_udf", bus.udf_err, 1'b0);
        write(2, rep(16'd1), 1'b1, 1'b0);
        write(2, rep(16'd2), 1'b0, 1'b0);
        write(2, rep(16'd3), 1'b0, 1'b1);
        chkb("acc_avail_before_done", bus.rd_avail, 1'b0);
        row_done();
        chkb("acc_avail_after_done", bus.rd_avail, 1'b1);
        chkb("acc_in_ready", bus.in_ready, 1'b1);
        read(2, rep(16'd6));
        chkb("acc_rd_valid_lat1", bus.rd_valid, 1'b1);
        tick();
        chkb("acc_rd_valid_drop", bus.rd_valid, 1'b0);
        release_bank();
        chkb("acc_avail_after_rel", bus.rd_avail, 1'b0);

        // Lane arithmetic table, one word per address.
        for (int i = 0; i < 6; i++) begin
            write(i, rep(vecs[i].a0), 1'b1, 1'b0);
            write(i, rep(vecs[i].a1), 1'b0, 1'b1);
        end
        row_done();
        for (int i = 0; i < 6; i++) begin
`ifdef SATURATE_EN
            read(i, rep(vecs[i].e_sat));
`else
            read(i, rep(vecs[i].e_wrap));
`endif
        end
        tick();
        release_bank();

        // Ping-pong: fill bank0, then fill bank1 while reading bank0.
        apply_reset();
        for (int a = 0; a < int'(DP); a++) write(a, pp(0, a), 1'b1, 1'b1);
        row_done();
        for (int a = 0; a < int'(DP); a++) begin
            bus.in_valid = 1'b1;
            bus.in_first = 1'b1;
            bus.in_last  = 1'b1;
            bus.in_addr  = AW'(a);
            bus.in_data  = pp(100, a);
            read(a, pp(0, a));
            chkb("pp_ready_or_avail", bus.in_ready | bus.rd_avail, 1'b1);
        end
        idle();
        tick();
        row_done();
        chkb("bp_in_ready_low", bus.in_ready, 1'b0);
        chkb("bp_rd_avail",     bus.rd_avail, 1'b1);
        chkb("bp_ovf_clear",    bus.ovf_err,  1'b0);

        // Dropped word must not disturb the accumulator.
        write(5, rep(16'd999), 1'b0, 1'b1);
        chkb("bp_ovf_set",      bus.ovf_err,  1'b1);
        chkb("bp_still_full",   bus.in_ready, 1'b0);
        bus.rd_release = 1'b1;
        read(7, pp(0, 7));
        bus.rd_release = 1'b0;
        chkb("bp_ready_after_rel", bus.in_ready, 1'b1);
        chkb("bp_avail_bank1",     bus.rd_avail, 1'b1);
        for (int a = 0; a < int'(DP); a++) read(a, pp(100, a));
        tick();

        write(5, rep(16'd1), 1'b0, 1'b1);
        row_done();
        chkb("both_full_ready", bus.in_ready, 1'b0);
        release_bank();
        read(5, pp(101, 31));
        tick();

        // Async reset in the middle of an accumulation.
        write(3, rep(16'd10), 1'b1, 1'b0);
        bus.rd_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chkb("mid_rst_in_ready", bus.in_ready, 1'b1);
        chkb("mid_rst_rd_avail", bus.rd_avail, 1'b0);
        chkb("mid_rst_rd_valid", bus.rd_valid, 1'b0);
        chk ("mid_rst_rd_data",  bus.rd_data,  '0);
        chkb("mid_rst_ovf_err",  bus.ovf_err,  1'b0);
        chkb("mid_rst_udf_err",  bus.udf_err,  1'b0);
        idle();
        #1;
        rst_n = 1'b1;
        tick();
        write(3, rep(16'd7), 1'b0, 1'b1);
        row_done();
        chkb("post_rst_avail", bus.rd_avail, 1'b1);
        read(3, rep(16'd7));
        tick();

        chkb("sb_drained", exp_q.size() == 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
